button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end stage for the up/down counter: takes the raw active-low KEY pins for "up" and "down", synchronises and debounces them, and emits clean single-cycle increment/decrement strobes. The strobes drive the counter's up/down inputs directly, so the counter needs no edge detection of its own. With auto-repeat compiled in, a held button keeps stepping the count at a fixed rate.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles needed to accept a level change (20 ms at 50 MHz).
- `REPEAT_DELAY`, 25_000_000: cycles from the first strobe to the first repeat strobe.
- `REPEAT_PERIOD`, 5_000_000: cycles between subsequent repeat strobes.
- `clk`  in  1  system clock, 50 MHz.
- `button_reset`  in  1  asynchronous, active-low reset.
- `key_up_n`  in  1  raw up button, asynchronous, 0 = pressed.
- `key_down_n`  in  1  raw down button, asynchronous, 0 = pressed.
- `up_pulse`  out  1  one-cycle increment strobe.
- `down_pulse`  out  1  one-cycle decrement strobe.
- `up_held`  out  1  debounced up level, 1 = pressed.
- `down_held`  out  1  debounced down level, 1 = pressed.

## Operation
- Per channel: invert the key, then a 2-FF synchroniser (`s1`, `s2`), a debounce counter and a stable level register `stable`.
  - Debounce counter: if `s2 == stable`, the counter clears.
  - Otherwise it increments. When it equals `DEBOUNCE_CYCLES-1`, `stable <= s2` and the counter clears.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles is rejected.
- `*_held` = `stable`.
- Per-channel FSM with states IDLE, WAIT_DELAY, REPEAT:
  - IDLE: on `stable` 0→1, emit a strobe and go to WAIT_DELAY with the timer cleared.
  - WAIT_DELAY: the timer counts. At `REPEAT_DELAY-1`, emit a strobe, clear the timer and go to REPEAT.
  - REPEAT: at `REPEAT_PERIOD-1`, emit a strobe and clear the timer.
  - From WAIT_DELAY or REPEAT, `stable` 0 → IDLE on the next edge. No strobe is emitted on release.
- Coincident strobes (up and down in the same cycle): only `up_pulse` asserts, and the down strobe is dropped. This matches the counter's up-over-down priority. Both FSMs otherwise run independently.
- Timer width is `$clog2` of the largest parameter. All counts are unsigned and never wrap in normal operation.
- Reset (asserted at any time, including mid-press or mid-repeat):
  - Clears the synchronisers, `stable`, the counters and the timers.
  - Forces both FSMs to IDLE.
  - All outputs read 0.
- A key held across reset release is seen as a fresh press, giving a strobe after the debounce latency.

## Timing
- Press latency: key low sampled at edge 0 → `*_pulse` high from edge `DEBOUNCE_CYCLES+2` to edge `DEBOUNCE_CYCLES+3`.
- `*_held` rises one cycle before the first strobe.
- Release latency: `*_held` falls `DEBOUNCE_CYCLES+1` edges after high is first sampled.
- Strobes are always exactly one cycle wide and registered, with no combinational path from the keys.
- Repeat cadence: the second strobe comes `REPEAT_DELAY` cycles after the first, then one every `REPEAT_PERIOD` cycles.

## Configuration
- `BUTTON_AUTOREPEAT_EN` defined: the full FSM with WAIT_DELAY and REPEAT is built.
- `BUTTON_AUTOREPEAT_EN` undefined:
  - The FSM and timers are removed, and `REPEAT_DELAY`/`REPEAT_PERIOD` are ignored.
  - Exactly one strobe per debounced press.
  - Debounce and arbitration behaviour are unchanged.

## Structure
- Package `button_pkg`: FSM state encoding (IDLE, WAIT_DELAY, REPEAT), plus width constants derived from the default parameters.
- Sub-module `button_channel`: synchroniser, debounce and FSM for one key. It is instantiated twice.
- The top level holds only the coincidence arbitration and the output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=3`, with `BUTTON_AUTOREPEAT_EN` defined unless stated.

1. Clean press: `key_up_n` goes 0 at edge 0 and is held 8 cycles → `up_held` high from edge 5; `up_pulse` high only edges 6–7; `down_pulse` stays 0.
2. Bounce: `key_up_n` toggles every 2 cycles for 20 cycles, then settles high → no strobe and `up_held` stays 0.
3. Auto-repeat: hold `key_down_n` low for 30 cycles after the first strobe → `down_pulse` asserts at +0, +10, +13, +16, +19, +22, +25, +28; then release → no further strobes.
4. Simultaneous: both keys go low at the same edge → `up_pulse` fires once and `down_pulse` stays 0 on that edge; both `*_held` are 1.
5. Reset mid-repeat: hold up into REPEAT, assert `button_reset` asynchronously → all outputs 0 immediately; key still low after release → a new strobe `DEBOUNCE_CYCLES+2` edges after the first edge sampling the key with `button_reset` deasserted.
6. Macro off: rebuild without `BUTTON_AUTOREPEAT_EN` and hold up for 40 cycles → exactly one `up_pulse`.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: shared FSM encoding, default timing constants and width helpers
// for the button conditioner. Auto-repeat is compiled in only when the
// BUTTON_AUTOREPEAT_EN macro is defined.
package button_pkg;

  // Per-channel auto-repeat states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_DELAY = 2'd1,
    ST_REPEAT     = 2'd2
  } btn_state_e;

  // Defaults for a 50 MHz clock
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000; // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;  // 100 ms

  // Counter width that can hold n-1, never narrower than one bit
  function automatic int unsigned clog2w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Shared counter width for the default parameter set
  localparam int unsigned DEF_CNT_W =
    clog2w(max3(DEF_DEBOUNCE_CYCLES, DEF_REPEAT_DELAY, DEF_REPEAT_PERIOD));

endpackage

// File: rtl/button_channel.sv
// button_channel: one key path -- invert, 2-FF synchroniser, debounce counter,
// stable level, and strobe generation (auto-repeat FSM when
// BUTTON_AUTOREPEAT_EN is defined, single rising-edge strobe otherwise).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_key_n         raw asynchronous key, 0 = pressed
//   o_held          debounced level, 1 = pressed (registered)
//   o_strobe_c      combinational strobe request from registered state only
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_held,
  output logic o_strobe_c
);

  localparam int unsigned CNT_W =
    clog2w(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_deb_cnt;

  // Synchroniser and debounce: a level is accepted only after it has
  // differed from the stable value for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_stable  <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_s1 <= ~i_key_n;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable  <= r_s2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + CNT_W'(1);
      end
    end
  end

  assign o_held = r_stable;

`ifdef BUTTON_AUTOREPEAT_EN
  btn_state_e       r_state;
  btn_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;

  // FSM state and repeat timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next state and strobe; release always wins over a timer match
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    o_strobe_c  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        // IDLE is only entered with stable low, so stable high here is a fresh press
        if (r_stable) begin
          o_strobe_c  = 1'b1;
          w_state_nxt = ST_WAIT_DELAY;
        end
      end
      ST_WAIT_DELAY: begin
        if (!r_stable) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == CNT_W'(REPEAT_DELAY - 1)) begin
          o_strobe_c  = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = ST_REPEAT;
        end else begin
          w_timer_nxt = r_timer + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!r_stable) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == CNT_W'(REPEAT_PERIOD - 1)) begin
          o_strobe_c  = 1'b1;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end
`else
  logic r_stable_d;

  // Previous stable level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_d <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
    end
  end

  assign o_strobe_c = r_stable & ~r_stable_d;
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced up/down key front end producing single-cycle
// increment/decrement strobes. Auto-repeat is built when BUTTON_AUTOREPEAT_EN
// is defined.
// Ports:
//   clk           system clock
//   button_reset  asynchronous active-low reset
//   key_up_n      raw up key, 0 = pressed
//   key_down_n    raw down key, 0 = pressed
//   up_pulse      one-cycle increment strobe (registered)
//   down_pulse    one-cycle decrement strobe (registered, loses to up)
//   up_held       debounced up level
//   down_held     debounced down level
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic button_reset,
  input  logic key_up_n,
  input  logic key_down_n,
  output logic up_pulse,
  output logic down_pulse,
  output logic up_held,
  output logic down_held
);

  logic w_up_strobe_c;
  logic w_down_strobe_c;
  logic r_up_pulse;
  logic r_down_pulse;

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_up (
    .clk        (clk),
    .rst_n      (button_reset),
    .i_key_n    (key_up_n),
    .o_held     (up_held),
    .o_strobe_c (w_up_strobe_c)
  );

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_down (
    .clk        (clk),
    .rst_n      (button_reset),
    .i_key_n    (key_down_n),
    .o_held     (down_held),
    .o_strobe_c (w_down_strobe_c)
  );

  // Output strobes; a coincident down strobe is dropped to match the
  // counter's up-over-down priority
  always_ff @(posedge clk or negedge button_reset) begin
    if (!button_reset) begin
      r_up_pulse   <= 1'b0;
      r_down_pulse <= 1'b0;
    end else begin
      r_up_pulse   <= w_up_strobe_c;
      r_down_pulse <= w_down_strobe_c & ~w_up_strobe_c;
    end
  end

  assign up_pulse   = r_up_pulse;
  assign down_pulse = r_down_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Expectations follow BUTTON_AUTOREPEAT_EN.
module tb_button_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RP  = 3;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk;
  logic button_reset;
  logic key_up_n;
  logic key_down_n;
  logic up_pulse;
  logic down_pulse;
  logic up_held;
  logic down_held;

  int n_checks;
  int n_errors;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk          (clk),
    .button_reset (button_reset),
    .key_up_n     (key_up_n),
    .key_down_n   (key_down_n),
    .up_pulse     (up_pulse),
    .down_pulse   (down_pulse),
    .up_held      (up_held),
    .down_held    (down_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // One active edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe expected at edge k for a press first sampled at edge 0:
  // first strobe at 'first', then (auto-repeat only) at first+RD and every RP
  // after that, up to and including 'stop'
  function automatic bit rep_hit(input int k, input int first, input int stop);
    if (k == first) return 1'b1;
    if (AUTO && k >= first + int'(RD) && k <= stop &&
        ((k - first - int'(RD)) % int'(RP)) == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_gap(input int n);
    key_up_n   = 1'b1;
    key_down_n = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    button_reset = 1'b0;
    key_up_n     = 1'b1;
    key_down_n   = 1'b1;

    // Reset state
    tick();
    tick();
    check_eq("rst up_pulse", 32'(up_pulse), 32'd0);
    check_eq("rst down_pulse", 32'(down_pulse), 32'd0);
    check_eq("rst up_held", 32'(up_held), 32'd0);
    check_eq("rst down_held", 32'(down_held), 32'd0);
    button_reset = 1'b1;
    idle_gap(4);

    // Clean press held 8 cycles: held 5..12, one strobe at edge 6
    for (int k = 0; k < 22; k++) begin
      key_up_n = (k < 8) ? 1'b0 : 1'b1;
      tick();
      check_eq($sformatf("press up_held e%0d", k), 32'(up_held), 32'(k >= 5 && k < 13));
      check_eq($sformatf("press up_pulse e%0d", k), 32'(up_pulse), 32'(k == 6));
      check_eq($sformatf("press down_pulse e%0d", k), 32'(down_pulse), 32'd0);
    end
    idle_gap(6);

    // Bounce: toggling every 2 cycles never reaches the debounce count
    for (int k = 0; k < 30; k++) begin
      key_up_n = (k < 20) ? (((k / 2) % 2) != 0) : 1'b1;
      tick();
      check_eq($sformatf("bounce up_held e%0d", k), 32'(up_held), 32'd0);
      check_eq($sformatf("bounce up_pulse e%0d", k), 32'(up_pulse), 32'd0);
    end
    idle_gap(6);

    // Down held long: key released at edge 31 so held drops at 36,
    // before the repeat slot at 37
    for (int k = 0; k < 45; k++) begin
      key_down_n = (k < 31) ? 1'b0 : 1'b1;
      tick();
      check_eq($sformatf("rep down_held e%0d", k), 32'(down_held), 32'(k >= 5 && k < 36));
      check_eq($sformatf("rep down_pulse e%0d", k), 32'(down_pulse), 32'(rep_hit(k, 6, 34)));
      check_eq($sformatf("rep up_pulse e%0d", k), 32'(up_pulse), 32'd0);
    end
    idle_gap(6);

    // Simultaneous press: up wins, down strobe always dropped
    for (int k = 0; k < 24; k++) begin
      key_up_n   = (k < 12) ? 1'b0 : 1'b1;
      key_down_n = (k < 12) ? 1'b0 : 1'b1;
      tick();
      check_eq($sformatf("sim up_held e%0d", k), 32'(up_held), 32'(k >= 5 && k < 17));
      check_eq($sformatf("sim down_held e%0d", k), 32'(down_held), 32'(k >= 5 && k < 17));
      check_eq($sformatf("sim up_pulse e%0d", k), 32'(up_pulse), 32'(rep_hit(k, 6, 16)));
      check_eq($sformatf("sim down_pulse e%0d", k), 32'(down_pulse), 32'd0);
    end
    idle_gap(6);

    // Reset mid-repeat: outputs clear asynchronously, key still low is a new press
    key_up_n = 1'b0;
    for (int k = 0; k < 21; k++) tick();
    check_eq("pre-reset up_held", 32'(up_held), 32'd1);
    #2;
    button_reset = 1'b0;
    #1;
    check_eq("async rst up_pulse", 32'(up_pulse), 32'd0);
    check_eq("async rst down_pulse", 32'(down_pulse), 32'd0);
    check_eq("async rst up_held", 32'(up_held), 32'd0);
    check_eq("async rst down_held", 32'(down_held), 32'd0);
    tick();
    check_eq("in rst up_held", 32'(up_held), 32'd0);
    check_eq("in rst up_pulse", 32'(up_pulse), 32'd0);
    button_reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_eq($sformatf("post-rst up_held e%0d", k), 32'(up_held), 32'(k >= 5));
      check_eq($sformatf("post-rst up_pulse e%0d", k), 32'(up_pulse), 32'(k == 6));
    end
    idle_gap(8);
    check_eq("final up_held", 32'(up_held), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
